f2h_sdram_arbiter: RTL and testbench

- Two-requester arbiter for the HPS FPGA-to-SDRAM port 0 Avalon-MM slave (26-bit word address, 128-bit data, bursting).
- Shares the port between, for example, an ADC capture writer (m0) and a readback/DMA reader (m1).
- Round-robin grant, write bursts locked until complete, read bursts tracked in a pending-owner FIFO so that readdatavalid is routed back to the issuer.
- Sits in the FPGA fabric between the requesters and the soc_system f2h_sdram0 data interface, clocked by the same clock as ddr3_hps_f2h_sdram0_clock_clk.

---
 rtl/f2h_arb_pkg.sv | 19 +
 rtl/f2h_sdram_arbiter_if.sv | 18 +
 rtl/f2h_arb_pend_fifo.sv | 44 ++++
 rtl/f2h_sdram_arbiter.sv | 110 +++++++++++
 tb/tb_f2h_sdram_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/f2h_arb_pkg.sv
// Shared widths, FSM state and pending-read entry type for the f2h_sdram0 two-port arbiter.
package f2h_arb_pkg;
  localparam int ADDR_W  = 26;
  localparam int DATA_W  = 128;
  localparam int BE_W    = DATA_W / 8;
  localparam int BURST_W = 9;

  typedef enum logic [1:0] {IDLE, CMD, WBURST} state_t;

  typedef struct packed {
    logic               owner;
    logic [BURST_W-1:0] len;
  } pend_t;

  // A burstcount of zero is handled as a single beat everywhere.
  function automatic logic [BURST_W-1:0] eff_len(input logic [BURST_W-1:0] bc);
    return (bc == '0) ? BURST_W'(1) : bc;
  endfunction
endpackage

// File: rtl/f2h_sdram_arbiter_if.sv
// Avalon-MM bursting bus bundle; master drives commands, slave answers with wait/read data.
interface f2h_sdram_arbiter_if;
  import f2h_arb_pkg::*;
  logic [ADDR_W-1:0]  address;
  logic               read;
  logic               write;
  logic [DATA_W-1:0]  writedata;
  logic [BE_W-1:0]    byteenable;
  logic [BURST_W-1:0] burstcount;
  logic               waitrequest;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;

  modport master (output address, read, write, writedata, byteenable, burstcount,
                  input  waitrequest, readdata, readdatavalid);
  modport slave  (input  address, read, write, writedata, byteenable, burstcount,
                  output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/f2h_arb_pend_fifo.sv
// Pending read owner/length FIFO; simultaneous push and pop are both honoured even when full.
module f2h_arb_pend_fifo
  import f2h_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  pend_t push_data,
  input  logic  pop,
  output pend_t head,
  output logic  full,
  output logic  empty
);
  localparam int PW = $clog2(DEPTH);

  pend_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          do_push, do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/f2h_sdram_arbiter.sv
// Round-robin two-requester arbiter for the HPS f2h_sdram0 port: write bursts are locked,
// read bursts are tagged in a pending FIFO so returning beats reach the issuing requester.
module f2h_sdram_arbiter
  import f2h_arb_pkg::*;
#(
  parameter int PEND_DEPTH = 8
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  f2h_sdram_arbiter_if.slave         m0,
  f2h_sdram_arbiter_if.slave         m1,
  f2h_sdram_arbiter_if.master        sdram,
  output logic                       err_orphan_rdv
);
  state_t             state;
  logic               g, last_grant;
  logic [BURST_W-1:0] beats_left, head_cnt, mg_len;
  logic               req0, req1, mg_rd, mg_wr;
  logic               full, empty, push, pop, rd_ok;
  logic               cmd_rd, cmd_wr, accept, stall, hit;
  pend_t              head, push_data;

  assign req0   = m0.read | m0.write;
  assign req1   = m1.read | m1.write;
  assign mg_rd  = g ? m1.read  : m0.read;
  assign mg_wr  = g ? m1.write : m0.write;
  assign mg_len = eff_len(g ? m1.burstcount : m0.burstcount);

  assign sdram.address    = g ? m1.address    : m0.address;
  assign sdram.writedata  = g ? m1.writedata  : m0.writedata;
  assign sdram.byteenable = g ? m1.byteenable : m0.byteenable;
  assign sdram.burstcount = g ? m1.burstcount : m0.burstcount;

  // A pop in this cycle frees a slot, so a read stalled on a full FIFO goes out in the pop cycle.
  assign rd_ok  = ~full | pop;
  assign cmd_wr = ((state == CMD) || (state == WBURST)) && mg_wr;
  assign cmd_rd = (state == CMD) && !mg_wr && mg_rd && rd_ok;
  assign sdram.read  = cmd_rd;
  assign sdram.write = cmd_wr;
  assign accept = (cmd_rd | cmd_wr) & ~sdram.waitrequest;
  assign push   = cmd_rd & ~sdram.waitrequest;
  assign push_data = '{owner: g, len: mg_len};

  assign stall = (state == IDLE) || ((state == CMD) && !mg_wr && mg_rd && !rd_ok)
                 || sdram.waitrequest;
  assign m0.waitrequest = g ? 1'b1  : stall;
  assign m1.waitrequest = g ? stall : 1'b1;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      g          <= 1'b0;
      last_grant <= 1'b1;
      beats_left <= '0;
    end else begin
      case (state)
        IDLE: if (req0 | req1) begin
          g     <= (req0 & req1) ? ~last_grant : req1;
          state <= CMD;
        end
        CMD: if (!(mg_rd | mg_wr)) begin
          state <= IDLE;
        end else if (accept) begin
          last_grant <= g;
          if (cmd_wr && mg_len > BURST_W'(1)) begin
            beats_left <= mg_len - BURST_W'(1);
            state      <= WBURST;
          end else begin
            state <= IDLE;
          end
        end
        WBURST: if (accept) begin
          beats_left <= beats_left - BURST_W'(1);
          if (beats_left == BURST_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return path runs independently of the command FSM.
  assign hit = sdram.readdatavalid & ~empty;
  assign pop = hit && ((head_cnt + BURST_W'(1)) == head.len);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      head_cnt       <= '0;
      err_orphan_rdv <= 1'b0;
    end else begin
      if (hit) head_cnt <= pop ? '0 : head_cnt + BURST_W'(1);
      if (sdram.readdatavalid && empty) err_orphan_rdv <= 1'b1;
    end
  end

  assign m0.readdatavalid = hit & ~head.owner;
  assign m1.readdatavalid = hit &  head.owner;
  assign m0.readdata      = sdram.readdata;
  assign m1.readdata      = sdram.readdata;

  f2h_arb_pend_fifo #(.DEPTH(PEND_DEPTH)) u_pend (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );
endmodule

// File: tb/tb_f2h_sdram_arbiter.sv
// Bench for f2h_sdram_arbiter: requester and SDRAM models with write/read scoreboards.
module tb_f2h_sdram_arbiter;
  import f2h_arb_pkg::*;

  typedef struct { logic wr; logic [ADDR_W-1:0] addr; logic [BURST_W-1:0] bc; } cmd_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [BURST_W-1:0] len; } ret_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; logic [BE_W-1:0] be; } wbeat_t;
  typedef struct { int who; logic wr; logic [ADDR_W-1:0] addr; logic [BURST_W-1:0] bc;
                   int exp_cmd; int exp_lat; int exp_rdv; } vec_t;

  localparam logic [BE_W-1:0] BE0 = 16'hFFFF;
  localparam logic [BE_W-1:0] BE1 = 16'h0F0F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;
  always #5 clk = ~clk;

  f2h_sdram_arbiter_if m0_if();
  f2h_sdram_arbiter_if m1_if();
  f2h_sdram_arbiter_if sd_if();

  f2h_sdram_arbiter #(.PEND_DEPTH(8)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .m0             (m0_if),
    .m1             (m1_if),
    .sdram          (sd_if),
    .err_orphan_rdv (err)
  );

  logic rd [2], wr [2], wreq [2], rdv [2];
  logic [ADDR_W-1:0]  addr [2];
  logic [DATA_W-1:0]  wd [2], rdata [2];
  logic [BURST_W-1:0] bc [2];
  logic sd_wait, sd_rdv;
  logic [DATA_W-1:0] sd_rdata;

  assign m0_if.read = rd[0];   assign m1_if.read = rd[1];
  assign m0_if.write = wr[0];  assign m1_if.write = wr[1];
  assign m0_if.address = addr[0]; assign m1_if.address = addr[1];
  assign m0_if.writedata = wd[0]; assign m1_if.writedata = wd[1];
  assign m0_if.burstcount = bc[0]; assign m1_if.burstcount = bc[1];
  assign m0_if.byteenable = BE0; assign m1_if.byteenable = BE1;
  assign wreq[0] = m0_if.waitrequest; assign wreq[1] = m1_if.waitrequest;
  assign rdv[0] = m0_if.readdatavalid; assign rdv[1] = m1_if.readdatavalid;
  assign rdata[0] = m0_if.readdata; assign rdata[1] = m1_if.readdata;
  assign sd_if.waitrequest = sd_wait;
  assign sd_if.readdatavalid = sd_rdv;
  assign sd_if.readdata = sd_rdata;

  cmd_t mq [2][$];
  int   mbeat [2];
  logic [DATA_W-1:0] exp_rd [2][$];
  wbeat_t exp_wr [$];
  ret_t   ret_q [$];
  int     grants [$];
  int  rbeat, stall_after, stall_cnt;
  bit  ret_en, m1_seen, order_bad;
  int  cyc, t0, first_cmd, n_cmd, n_wacc;
  int  wlow [2], cnt_rdv [2];
  int  errors = 0, checks = 0;
  vec_t vt [6];

  function automatic logic [DATA_W-1:0] rdat(input logic [ADDR_W-1:0] a, input int b);
    return {32'hCAFE0000 ^ 32'(b), 38'd0, a, 32'(b)};
  endfunction
  function automatic logic [DATA_W-1:0] wdat(input int who, input logic [ADDR_W-1:0] a, input int b);
    return {32'h5EED0000 ^ 32'(who), 38'd0, a, 32'(b)};
  endfunction
  function automatic int blen(input logic [BURST_W-1:0] c);
    return (c == '0) ? 1 : int'(c);
  endfunction

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_masters();
    for (int i = 0; i < 2; i++) begin
      if (mq[i].size() > 0) begin
        rd[i] = !mq[i][0].wr; wr[i] = mq[i][0].wr;
        addr[i] = mq[i][0].addr; bc[i] = mq[i][0].bc;
        wd[i] = wdat(i, mq[i][0].addr, mbeat[i]);
      end else begin
        rd[i] = 1'b0; wr[i] = 1'b0;
      end
    end
  endtask

  task automatic issue(input int who, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [BURST_W-1:0] c);
    cmd_t cm;
    wbeat_t wb;
    cm.wr = w; cm.addr = a; cm.bc = c;
    mq[who].push_back(cm);
    for (int b = 0; b < blen(c); b++) begin
      if (w) begin
        wb.addr = a; wb.data = wdat(who, a, b); wb.be = (who == 0) ? BE0 : BE1;
        exp_wr.push_back(wb);
      end else exp_rd[who].push_back(rdat(a, b));
    end
    drive_masters();
  endtask

  task automatic clear_stats();
    t0 = cyc; first_cmd = -1; n_cmd = 0; n_wacc = 0;
    m1_seen = 0; order_bad = 0; grants.delete();
    for (int i = 0; i < 2; i++) begin wlow[i] = 0; cnt_rdv[i] = 0; end
  endtask

  // One clock: observe at the falling edge, then update models just after the rising edge.
  task automatic step();
    wbeat_t e;
    @(negedge clk);
    if (sd_if.read || sd_if.write) begin
      n_cmd++;
      if (first_cmd < 0) first_cmd = cyc - t0;
    end
    if (sd_if.write && !sd_wait) begin
      n_wacc++;
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_unexpected: write beat at %0h, none expected", sd_if.address);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_addr", sd_if.address, e.addr);
        chk("wr_data", sd_if.writedata, e.data);
        chk("wr_be", sd_if.byteenable, e.be);
      end
    end
    if (sd_if.read && !sd_wait) begin
      ret_t r;
      r.addr = sd_if.address; r.len = sd_if.burstcount;
      ret_q.push_back(r);
    end
    for (int i = 0; i < 2; i++) begin
      if (!wreq[i]) wlow[i]++;
      if ((rd[i] || wr[i]) && !wreq[i]) begin
        if (rd[i]) begin
          grants.push_back(i);
          void'(mq[i].pop_front());
        end else begin
          mbeat[i]++;
          if (mbeat[i] == blen(bc[i])) begin void'(mq[i].pop_front()); mbeat[i] = 0; end
        end
      end
      if (rdv[i]) begin
        cnt_rdv[i]++;
        if (i == 1) m1_seen = 1; else if (m1_seen) order_bad = 1;
        if (exp_rd[i].size() == 0) begin
          checks++; errors++;
          $display("FAIL rdv_unexpected: m%0d readdatavalid with no read expected", i);
        end else chk($sformatf("rd_data_m%0d", i), rdata[i], exp_rd[i].pop_front());
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (stall_after >= 0 && n_wacc == stall_after) begin stall_cnt = 3; stall_after = -1; end
    sd_wait = (stall_cnt > 0);
    if (stall_cnt > 0) stall_cnt--;
    if (ret_en && ret_q.size() > 0) begin
      sd_rdv = 1'b1;
      sd_rdata = rdat(ret_q[0].addr, rbeat);
      rbeat++;
      if (rbeat == blen(ret_q[0].len)) begin void'(ret_q.pop_front()); rbeat = 0; end
    end else sd_rdv = 1'b0;
    drive_masters();
  endtask

  task automatic drain(input string nm, input int maxc);
    int n = 0;
    while ((mq[0].size() > 0 || mq[1].size() > 0 || (ret_en && ret_q.size() > 0)) && n < maxc) begin
      step(); n++;
    end
    checks++;
    if (n >= maxc) begin errors++; $display("FAIL %s_timeout: still busy after %0d cycles", nm, n); end
    repeat (3) step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, c0, alt;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 0; wr[i] = 0; addr[i] = '0; wd[i] = '0; bc[i] = '0; mbeat[i] = 0;
    end
    sd_wait = 0; sd_rdv = 0; sd_rdata = '0; rbeat = 0; stall_after = -1; stall_cnt = 0;
    ret_en = 1; cyc = 0;
    clear_stats();

    // Reset state, with a write request held during reset
    wr[0] = 1'b1; bc[0] = 9'd1;
    #12;
    chk("rst_sd_write", sd_if.write, 1'b0);
    chk("rst_sd_read", sd_if.read, 1'b0);
    chk("rst_m0_wait", wreq[0], 1'b1);
    chk("rst_m1_wait", wreq[1], 1'b1);
    chk("rst_m0_rdv", rdv[0], 1'b0);
    chk("rst_err", err, 1'b0);
    wr[0] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (2) step();

    // Table: single transactions from idle, one requester at a time
    vt[0] = '{0, 1'b1, 26'h0000100, 9'd1, 1, 1, 0};
    vt[1] = '{1, 1'b1, 26'h0001234, 9'd0, 1, 1, 0};
    vt[2] = '{0, 1'b1, 26'h0002000, 9'd3, 3, 1, 0};
    vt[3] = '{0, 1'b0, 26'h0003000, 9'd4, 1, 1, 4};
    vt[4] = '{1, 1'b0, 26'h0003100, 9'd0, 1, 1, 1};
    vt[5] = '{1, 1'b1, 26'h00000AB, 9'd2, 2, 1, 0};
    for (int v = 0; v < 6; v++) begin
      clear_stats();
      issue(vt[v].who, vt[v].wr, vt[v].addr, vt[v].bc);
      drain($sformatf("vec%0d", v), 100);
      chk($sformatf("vec%0d_cmd_cycles", v), n_cmd, vt[v].exp_cmd);
      chk($sformatf("vec%0d_latency", v), first_cmd, vt[v].exp_lat);
      chk($sformatf("vec%0d_other_wait_low", v), wlow[1 - vt[v].who], 0);
      chk($sformatf("vec%0d_rdv_own", v), cnt_rdv[vt[v].who], vt[v].exp_rdv);
      chk($sformatf("vec%0d_rdv_other", v), cnt_rdv[1 - vt[v].who], 0);
    end

    // Simultaneous burst-4 writes, 3-cycle stall after the second m0 beat
    clear_stats();
    stall_after = 2;
    issue(0, 1'b1, 26'h0010000, 9'd4);
    issue(1, 1'b1, 26'h0020000, 9'd4);
    drain("wr_pair", 200);
    chk("wr_pair_beats", n_wacc, 8);
    chk("wr_pair_left", exp_wr.size(), 0);

    // m0 read burst 8 then m1 read burst 2, returned afterwards
    ret_en = 0;
    issue(0, 1'b0, 26'h0030000, 9'd8);
    drain("rd8_issue", 50);
    issue(1, 1'b0, 26'h0040000, 9'd2);
    drain("rd2_issue", 50);
    clear_stats();
    ret_en = 1;
    drain("rd_return", 100);
    chk("rd_m0_beats", cnt_rdv[0], 8);
    chk("rd_m1_beats", cnt_rdv[1], 2);
    chk("rd_order", order_bad, 0);
    chk("rd_left_m0", exp_rd[0].size(), 0);

    // Eight outstanding reads fill the FIFO; the ninth waits for the first pop
    ret_en = 0;
    clear_stats();
    for (int k = 0; k < 8; k++) issue(0, 1'b0, ADDR_W'(32'h400 + k), 9'd1);
    drain("fill", 100);
    chk("fill_grants", grants.size(), 8);
    issue(0, 1'b0, 26'h0000500, 9'd1);
    repeat (5) step();
    #1;
    chk("full_sd_read", sd_if.read, 1'b0);
    chk("full_m0_wait", wreq[0], 1'b1);
    chk("full_grants", grants.size(), 8);
    ret_en = 1;
    step();
    #1;
    chk("pop_rdv", rdv[0], 1'b1);
    chk("pop_sd_read", sd_if.read, 1'b1);
    chk("pop_m0_wait", wreq[0], 1'b0);
    drain("full_drain", 100);
    chk("full_total_grants", grants.size(), 9);
    chk("full_rd_left", exp_rd[0].size(), 0);

    // Reset during a write burst with two reads still pending
    ret_en = 0;
    issue(0, 1'b0, 26'h0000600, 9'd1);
    issue(0, 1'b0, 26'h0000601, 9'd1);
    drain("rst_reads", 50);
    clear_stats();
    issue(0, 1'b1, 26'h0000700, 9'd8);
    n = 0;
    while (n_wacc < 3 && n < 50) begin step(); n++; end
    chk("rst_burst_reached", n_wacc, 3);
    rst_n = 1'b0;
    sd_rdv = 1'b1;
    #1;
    chk("mid_rst_sd_write", sd_if.write, 1'b0);
    chk("mid_rst_sd_read", sd_if.read, 1'b0);
    chk("mid_rst_m0_wait", wreq[0], 1'b1);
    chk("mid_rst_m1_wait", wreq[1], 1'b1);
    chk("mid_rst_m0_rdv", rdv[0], 1'b0);
    chk("mid_rst_err", err, 1'b0);
    sd_rdv = 1'b0;
    for (int i = 0; i < 2; i++) begin mq[i].delete(); exp_rd[i].delete(); mbeat[i] = 0; end
    exp_wr.delete();
    drive_masters();
    #2;
    rst_n = 1'b1;
    clear_stats();
    ret_en = 1;
    drain("orphan", 50);
    chk("orphan_err", err, 1'b1);
    chk("orphan_m0_rdv", cnt_rdv[0], 0);
    chk("orphan_m1_rdv", cnt_rdv[1], 0);

    // Fairness: continuous burst-1 reads from both requesters
    clear_stats();
    for (int k = 0; k < 10; k++) begin
      issue(0, 1'b0, ADDR_W'(32'h800 + k), 9'd1);
      issue(1, 1'b0, ADDR_W'(32'h900 + k), 9'd1);
    end
    drain("rr", 400);
    c0 = 0; alt = 0;
    foreach (grants[k]) begin
      if (grants[k] == 0) c0++;
      if (k > 0 && grants[k] == grants[k-1]) alt++;
    end
    chk("rr_grants", grants.size(), 20);
    chk("rr_m0_grants", c0, 10);
    chk("rr_repeats", alt, 0);
    chk("rr_rd_left", exp_rd[0].size() + exp_rd[1].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
